bus_tx_arbiter: RTL and testbench



---
 rtl/bus_pkg.sv | 20 ++
 rtl/rr_arbiter4.sv | 15 +
 rtl/bus_tx_arbiter.sv | 98 +++++++++
 tb/tb_bus_tx_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared frame layout and state type for the bus transmitter and receiver
// BUS_TX_PARITY_EN adds the PARITY state and one parity bit to the frame.
package bus_pkg;
    localparam int ID_W = 4;
    localparam int DATA_W = 8;
    localparam int PAYLOAD_BITS = 2 * ID_W + DATA_W;
    localparam int DEST_OFF = ID_W + DATA_W;
    localparam int SRC_OFF = DATA_W;
    localparam int DATA_OFF = 0;
`ifdef BUS_TX_PARITY_EN
    localparam int FRAME_BITS = PAYLOAD_BITS + 3;
    typedef enum logic [2:0] {S_IDLE, S_ARB, S_START, S_SHIFT, S_PARITY, S_STOP, S_GAP} state_t;
`else
    localparam int FRAME_BITS = PAYLOAD_BITS + 2;
    typedef enum logic [2:0] {S_IDLE, S_ARB, S_START, S_SHIFT, S_STOP, S_GAP} state_t;
`endif
    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction
endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: 4-way round-robin pick, searching from the requester after last_grant
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] last_grant,
    output logic [3:0] grant,
    output logic       valid
);
    // walk from lowest to highest priority so the nearest requester wins
    always_comb begin
        grant = '0;
        for (int k = 4; k >= 1; k--)
            if (req[last_grant + 2'(k)]) grant = 4'b0001 << (last_grant + 2'(k));
    end
    assign valid = |req;
endmodule

// File: rtl/bus_tx_arbiter.sv
// bus_tx_arbiter: round-robin arbitrated serial frame transmitter
// Define BUS_TX_PARITY_EN to send an even parity bit between data and stop.
module bus_tx_arbiter
    import bus_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int IFG_BITS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  node_id,
    input  logic        bus_busy,
    input  logic [3:0]  req,
    input  logic [15:0] req_dest,
    input  logic [31:0] req_data,
    output logic [3:0]  ack,
    output logic [3:0]  done,
    output logic        tx,
    output logic        busy
);
    localparam logic [7:0] LAST_CLK = 8'(CLKS_PER_BIT - 1);
    localparam logic [3:0] LAST_GAP = 4'(IFG_BITS - 1);
    localparam logic [3:0] LAST_BIT = 4'(PAYLOAD_BITS - 1);
    state_t state, state_nxt;
    logic [7:0] clk_cnt;
    logic [3:0] bit_cnt, grant;
    logic [1:0] last_grant, win;
    logic valid, bit_end, take;
    logic [PAYLOAD_BITS-1:0] sh, payload;
`ifdef BUS_TX_PARITY_EN
    logic par;
`endif

    rr_arbiter4 u_rr (.req(req), .last_grant(last_grant), .grant(grant), .valid(valid));

    assign win = oh2idx(grant);
    assign bit_end = clk_cnt == LAST_CLK;
    assign take = state == S_ARB && valid && !bus_busy;

    always_comb begin
        payload = '0;
        payload[DEST_OFF +: ID_W] = req_dest[{win, 2'b00} +: ID_W];
        payload[SRC_OFF +: ID_W] = node_id;
        payload[DATA_OFF +: DATA_W] = req_data[{win, 3'b000} +: DATA_W];
    end

    always_ff @(posedge clk) state <= !rst_n ? S_IDLE : state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = (|req && !bus_busy) ? S_ARB : S_IDLE;
            S_ARB:    state_nxt = take ? S_START : S_IDLE;
            S_START:  state_nxt = bit_end ? S_SHIFT : S_START;
`ifdef BUS_TX_PARITY_EN
            S_SHIFT:  state_nxt = (bit_end && bit_cnt == LAST_BIT) ? S_PARITY : S_SHIFT;
            S_PARITY: state_nxt = bit_end ? S_STOP : S_PARITY;
`else
            S_SHIFT:  state_nxt = (bit_end && bit_cnt == LAST_BIT) ? S_STOP : S_SHIFT;
`endif
            S_STOP:   state_nxt = bit_end ? (IFG_BITS == 0 ? S_IDLE : S_GAP) : S_STOP;
            S_GAP:    state_nxt = (bit_end && bit_cnt == LAST_GAP) ? S_IDLE : S_GAP;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // bit_cnt counts payload bits in SHIFT and idle bit periods in GAP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            last_grant <= 2'd3;
            sh <= '0;
        end else begin
            clk_cnt <= (state_nxt != state || bit_end) ? '0 : clk_cnt + 8'd1;
            bit_cnt <= (state_nxt != state) ? '0 :
                       (bit_end && (state == S_SHIFT || state == S_GAP)) ? bit_cnt + 4'd1 : bit_cnt;
            if (take) begin
                last_grant <= win;
                sh <= payload;
            end else if (state == S_SHIFT && bit_end) sh <= sh << 1;
        end
    end

`ifdef BUS_TX_PARITY_EN
    always_ff @(posedge clk) par <= !rst_n ? 1'b0 : take ? ^payload : par;
`endif

    always_comb begin
        ack = take ? grant : '0;
        done = (state == S_STOP && bit_end) ? 4'b0001 << last_grant : '0;
        busy = state != S_IDLE;
        tx = state == S_START ? 1'b0 : state == S_SHIFT ? sh[PAYLOAD_BITS-1] : 1'b1;
`ifdef BUS_TX_PARITY_EN
        if (state == S_PARITY) tx = par;
`endif
    end
endmodule

// File: tb/tb_bus_tx_arbiter.sv
// tb_bus_tx_arbiter: directed and randomized frame checks against a bit-level frame model
module tb_bus_tx_arbiter;
    localparam int C = 8;
    localparam int IFG = 2;
`ifdef BUS_TX_PARITY_EN
    localparam int F = 19;
`else
    localparam int F = 18;
`endif
    logic clk = 1'b0, rst_n = 1'b0, bus_busy = 1'b0, tx, busy;
    logic [3:0] node_id = '0, req = '0, ack, done;
    logic [15:0] req_dest = '0;
    logic [31:0] req_data = '0;
    int tests = 0, fails = 0, m_last = 3, e, t, bad;

    always #5 clk = ~clk;

    bus_tx_arbiter #(.CLKS_PER_BIT(C), .IFG_BITS(IFG)) dut (
        .clk(clk), .rst_n(rst_n), .node_id(node_id), .bus_busy(bus_busy), .req(req),
        .req_dest(req_dest), .req_data(req_data), .ack(ack), .done(done), .tx(tx), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    task automatic do_reset;
        bus_busy = 1'b0;
        req = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_last = 3;
    endtask

    // waits for the grant, then checks every cycle of the frame and the gap after it
    task automatic run_frame(input int ei, input logic [3:0] ed, input logic [7:0] edat, input logic [3:0] req_after);
        logic [F-1:0] bits;
        logic [3:0] done_end;
        int w, bad_tx, bad_ack, bad_done, g;
`ifdef BUS_TX_PARITY_EN
        bits = {1'b0, ed, node_id, edat, ^{ed, node_id, edat}, 1'b1};
`else
        bits = {1'b0, ed, node_id, edat, 1'b1};
`endif
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (ack === 4'b0 && w < 50);
        chk("ack_latency", w, 1);
        chk("ack_grant", 32'(ack), 32'(1) << ei);
        bad_tx = 0;
        bad_ack = 0;
        bad_done = 0;
        done_end = '0;
        for (int n = 0; n < F * C; n++) begin
            @(negedge clk);
            if (tx !== bits[F-1-n/C]) bad_tx++;
            if (ack !== 4'b0) bad_ack++;
            if (n < F * C - 1 && done !== 4'b0) bad_done++;
            done_end = done;
            if (n == 0) begin
                req = req_after;
                req_dest = 16'($urandom);
                req_data = $urandom;
            end
            bus_busy = (n < F * C - 2) ? 1'($urandom) : 1'b0;
        end
        chk("frame_bits", bad_tx, 0);
        chk("ack_in_frame", bad_ack, 0);
        chk("done_early", bad_done, 0);
        chk("done_end", 32'(done_end), 32'(1) << ei);
        g = 0;
        @(negedge clk);
        while (busy === 1'b1 && g < 500) begin
            if (tx !== 1'b1 || done !== 4'b0) bad_tx++;
            g++;
            @(negedge clk);
        end
        chk("gap_len", g, IFG * C);
        chk("gap_tx", bad_tx, 0);
        m_last = ei;
    endtask

    initial begin
        do_reset;
        chk("rst_tx", 32'(tx), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_done", 32'(done), 0);
        // single known frame
        node_id = 4'h3;
        req_dest = 16'h0005;
        req_data = 32'h0000_00A5;
        req = 4'b0001;
        run_frame(0, 4'h5, 8'hA5, 4'b0000);
        // all requesters held: strict rotation from requester 0
        do_reset;
        req_dest = 16'($urandom);
        req_data = $urandom;
        req = 4'b1111;
        for (int i = 0; i < 5; i++)
            run_frame(i % 4, req_dest[4*(i%4) +: 4], req_data[8*(i%4) +: 8], i == 4 ? 4'b0000 : 4'b1111);
        // carrier sense holds off arbitration
        bus_busy = 1'b1;
        req = 4'b0010;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (ack !== 4'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("busy_hold", bad, 0);
        bus_busy = 1'b0;
        run_frame(1, req_dest[7:4], req_data[15:8], 4'b0000);
        // reset during the data field
        req = 4'b0001;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (ack === 4'b0 && t < 50);
        chk("mid_ack", 32'(ack), 1);
        @(negedge clk);
        req = 4'b0000;
        repeat (86) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_tx", 32'(tx), 1);
        chk("mid_rst_busy", 32'(busy), 0);
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (done !== 4'b0 || ack !== 4'b0 || busy !== 1'b0) bad++;
        end
        chk("mid_rst_quiet", bad, 0);
        m_last = 3;
        req = 4'b0010;
        run_frame(1, req_dest[7:4], req_data[15:8], 4'b0000);
        // aborted arbitration must leave the rotation pointer at 1
        req = 4'b0100;
        @(posedge clk);
        #1;
        req = 4'b0000;
        bus_busy = 1'b1;
        @(negedge clk);
        chk("abort_ack", 32'(ack), 0);
        chk("abort_in_arb", 32'(busy), 1);
        @(negedge clk);
        chk("abort_idle", 32'(busy), 0);
        bus_busy = 1'b0;
        req = 4'b1111;
        run_frame(2, req_dest[11:8], req_data[23:16], 4'b0000);
        // random request patterns against the round-robin model
        for (int i = 0; i < 8; i++) begin
            node_id = 4'($urandom);
            req = 4'($urandom_range(1, 15));
            e = rr_pick(req, m_last);
            run_frame(e, req_dest[4*e +: 4], req_data[8*e +: 8], i == 7 ? 4'b0000 : 4'b1111);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
